// File: rtl/pc_fetch.sv
// Program-counter fetch sequencer: IDLE/RUN/DONE control with stall, relative branch and halt.
// Optional PC_CYCLE_CTR_EN adds a saturating 16-bit RUN-cycle counter on port cycle_ctr.
module pc_fetch #(
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         branch_cond,
  input  logic [D-1:0] target,
  input  logic         halt,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
`ifdef PC_CYCLE_CTR_EN
  output logic         done,
  output logic [15:0]  cycle_ctr
`else
  output logic         done
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [D-1:0]   pc_nx;
  logic           fv_nx;
  logic           done_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prog_ctr    <= '0;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      prog_ctr    <= pc_nx;
      fetch_valid <= fv_nx;
      done        <= done_nx;
    end
  end

  // Outputs are registered: their next values are derived from the next state.
  always_comb begin
    state_nx = state;
    pc_nx    = prog_ctr;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          pc_nx    = '0;
        end
      end
      RUN: begin
        if (halt) begin
          state_nx = DONE;
        end else if (stall) begin
          pc_nx = prog_ctr;
        end else if (branch_en && branch_cond) begin
          pc_nx = prog_ctr + target;
        end else begin
          pc_nx = prog_ctr + D'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_nx = RUN;
          pc_nx    = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        pc_nx    = '0;
      end
    endcase
    fv_nx   = (state_nx == RUN);
    done_nx = (state_nx == DONE);
  end

`ifdef PC_CYCLE_CTR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_ctr <= '0;
    end else if (state != RUN && start) begin
      cycle_ctr <= '0;
    end else if (state == RUN && cycle_ctr != '1) begin
      cycle_ctr <= cycle_ctr + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with D=12.
module tb_pc_fetch;
  localparam int D = 12;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stall;
  logic         branch_en;
  logic         branch_cond;
  logic [D-1:0] target;
  logic         halt;
  logic [D-1:0] prog_ctr;
  logic         fetch_valid;
  logic         done;
`ifdef PC_CYCLE_CTR_EN
  logic [15:0]  cycle_ctr;
`endif

  int checks;
  int failures;

  pc_fetch #(.D(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_cond (branch_cond),
    .target      (target),
    .halt        (halt),
    .prog_ctr    (prog_ctr),
    .fetch_valid (fetch_valid),
`ifdef PC_CYCLE_CTR_EN
    .done        (done),
    .cycle_ctr   (cycle_ctr)
`else
    .done        (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_cond = 1'b0;
    target = '0; halt = 1'b0;
  endtask

  // Reset, start, and advance with plain increments until PC equals pc.
  task automatic go_to(input int pc);
    clear_inputs();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < pc; i++) step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    checks++;
    if (prog_ctr !== 12'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pc=%0d fv=%b done=%b, want pc=0 fv=0 done=0", prog_ctr, fetch_valid, done);
    end
    #3;
    reset = 1'b0;
    branch_en = 1'b1; branch_cond = 1'b1; target = 12'd50; halt = 1'b1;
    step(); step();
    checks++;
    if (prog_ctr !== 12'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore: pc=%0d fv=%b done=%b, want pc=0 fv=0 done=0", prog_ctr, fetch_valid, done);
    end
    clear_inputs();
  endtask

  task automatic test_plain();
    logic [D-1:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = D'(i);
      checks++;
      if (prog_ctr !== exp || fetch_valid !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL plain_%0d: pc=%0d fv=%b done=%b, want pc=%0d fv=1 done=0", i, prog_ctr, fetch_valid, done, exp);
      end
      if (i < 3) step();
    end
  endtask

  task automatic test_branch();
    go_to(10);
    branch_en = 1'b1; branch_cond = 1'b1; target = 12'hF14;
    step();
    checks++;
    if (prog_ctr !== 12'hF1E) begin
      failures++;
      $display("FAIL branch_neg: pc=%h, want f1e", prog_ctr);
    end
    branch_cond = 1'b0;
    step();
    checks++;
    if (prog_ctr !== 12'hF1F) begin
      failures++;
      $display("FAIL branch_not_taken: pc=%h, want f1f", prog_ctr);
    end
    branch_cond = 1'b1; target = 12'd0;
    step(); step();
    checks++;
    if (prog_ctr !== 12'hF1F || fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL self_loop: pc=%h fv=%b, want f1f fv=1", prog_ctr, fetch_valid);
    end
    clear_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (prog_ctr !== 12'hF20 || fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL start_in_run: pc=%h fv=%b, want f20 fv=1", prog_ctr, fetch_valid);
    end
  endtask

  task automatic test_wrap();
    go_to(0);
    branch_en = 1'b1; branch_cond = 1'b1; target = 12'hFFF;
    step();
    clear_inputs();
    checks++;
    if (prog_ctr !== 12'd4095) begin
      failures++;
      $display("FAIL wrap_setup: pc=%0d, want 4095", prog_ctr);
    end
    step();
    checks++;
    if (prog_ctr !== 12'd0 || fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap: pc=%0d fv=%b, want pc=0 fv=1", prog_ctr, fetch_valid);
    end
`ifdef PC_CYCLE_CTR_EN
    checks++;
    if (cycle_ctr !== 16'd2) begin
      failures++;
      $display("FAIL wrap_cycle_ctr: cycle_ctr=%0d, want 2", cycle_ctr);
    end
`endif
  endtask

  task automatic test_halt();
    go_to(5);
    halt = 1'b1; branch_en = 1'b1; branch_cond = 1'b1; target = 12'd100; stall = 1'b1;
    step();
    checks++;
    if (prog_ctr !== 12'd5 || done !== 1'b1 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt: pc=%0d done=%b fv=%b, want pc=5 done=1 fv=0", prog_ctr, done, fetch_valid);
    end
    halt = 1'b0; stall = 1'b0;
    step(); step();
    checks++;
    if (prog_ctr !== 12'd5 || done !== 1'b1 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_hold: pc=%0d done=%b fv=%b, want pc=5 done=1 fv=0", prog_ctr, done, fetch_valid);
    end
`ifdef PC_CYCLE_CTR_EN
    checks++;
    if (cycle_ctr !== 16'd6) begin
      failures++;
      $display("FAIL done_cycle_ctr: cycle_ctr=%0d, want 6", cycle_ctr);
    end
`endif
    clear_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (prog_ctr !== 12'd0 || done !== 1'b0 || fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart: pc=%0d done=%b fv=%b, want pc=0 done=0 fv=1", prog_ctr, done, fetch_valid);
    end
  endtask

  task automatic test_stall();
    go_to(7);
    stall = 1'b1; branch_en = 1'b1; branch_cond = 1'b1; target = 12'd126;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (prog_ctr !== 12'd7 || fetch_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d: pc=%0d fv=%b, want pc=7 fv=1", i, prog_ctr, fetch_valid);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (prog_ctr !== 12'd133) begin
      failures++;
      $display("FAIL stall_release: pc=%0d, want 133", prog_ctr);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    go_to(20);
    checks++;
    if (prog_ctr !== 12'd20) begin
      failures++;
      $display("FAIL reset_mid_setup: pc=%0d, want 20", prog_ctr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (prog_ctr !== 12'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: pc=%0d fv=%b done=%b, want pc=0 fv=0 done=0", prog_ctr, fetch_valid, done);
    end
    #1;
    reset = 1'b0;
    step(); step();
    checks++;
    if (prog_ctr !== 12'd0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: pc=%0d fv=%b, want pc=0 fv=0", prog_ctr, fetch_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_plain();
    test_branch();
    test_wrap();
    test_halt();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
